// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, fault causes,
// controller states and the funct3 legality rule.
package lsu_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_RANGE    = 2'd2;
    localparam logic [1:0] CAUSE_FUNCT3   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FAULT,
        S_ST_WR,
        S_LD_REQ,
        S_LD_WAIT,
        S_LD_RESP
    } state_e;

    // Stores only have signed-less widths; loads add the unsigned byte/half forms.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data replication and byte enables on the way out,
// lane extraction with sign/zero extension on the way back.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_byte_off,
    input  logic [WORD_W-1:0] i_store_data,
    input  logic [WORD_W-1:0] i_mem_rdata,
    output logic [BE_W-1:0]   o_be,
    output logic [WORD_W-1:0] o_wdata,
    output logic [WORD_W-1:0] o_load_data
);

    logic [WORD_W-1:0] w_lane;
    logic              w_sext;

    assign w_lane = i_mem_rdata >> {i_byte_off, 3'b000};
    assign w_sext = ~i_funct3[2];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = w_lane;
        case (i_funct3[1:0])
            2'b00: begin
                o_be        = 4'b0001 << i_byte_off;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {{24{w_sext & w_lane[7]}}, w_lane[7:0]};
            end
            2'b01: begin
                o_be        = 4'b0011 << i_byte_off;
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = {{16{w_sext & w_lane[15]}}, w_lane[15:0]};
            end
            default: begin
                o_be        = 4'b1111;
                o_wdata     = i_store_data;
                o_load_data = w_lane;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit between execute and a single-port data memory: one access
// at a time with valid/ready intake, configurable read latency and fault pulses.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_is_store,
    input  logic [2:0]        i_funct3,
    input  logic [XLEN-1:0]   i_rs1_val,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [XLEN-1:0]   i_rs2_val,
    input  logic [4:0]        i_rd,
    output logic              o_stall_pc,
    output logic              o_busy,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [3:0]        o_mem_be,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_load_valid,
    output logic [4:0]        o_load_rd,
    output logic [XLEN-1:0]   o_load_data,
    output logic              o_done,
    output logic              o_fault,
    output logic [1:0]        o_fault_cause
);

    if (XLEN != 32) begin : g_xlen_check
        $error("lsu_mem_port: only XLEN=32 is supported");
    end
    if (ADDR_W + 2 >= XLEN) begin : g_addr_check
        $error("lsu_mem_port: ADDR_W must leave room for an out-of-range field");
    end
    if (RD_LAT < 1) begin : g_lat_check
        $error("lsu_mem_port: RD_LAT must be at least 1");
    end

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e            r_state;
    logic              r_req_ready;
    logic              r_busy;
    logic [2:0]        r_funct3;
    logic [1:0]        r_byte_off;
    logic [4:0]        r_rd;
    logic [CNT_W-1:0]  r_lat_cnt;

    logic              r_mem_we;
    logic              r_mem_re;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [3:0]        r_mem_be;
    logic              r_load_valid;
    logic [4:0]        r_load_rd;
    logic [XLEN-1:0]   r_load_data;
    logic              r_done;
    logic              r_fault;
    logic [1:0]        r_fault_cause;

    logic [XLEN-1:0]   w_ea;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic [1:0]        w_cause;
    logic              w_idle;
    logic [2:0]        w_al_funct3;
    logic [1:0]        w_al_off;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_load_data;

    assign w_ea           = i_rs1_val + i_imm;
    assign w_misaligned   = ((i_funct3[1:0] == 2'b01) && w_ea[0]) ||
                            ((i_funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
    assign w_out_of_range = |w_ea[XLEN-1:ADDR_W+2];

    always_comb begin
        w_cause = CAUSE_NONE;
        if (!funct3_legal(i_is_store, i_funct3))
            w_cause = CAUSE_FUNCT3;
        else if (w_misaligned)
            w_cause = CAUSE_MISALIGN;
        else if (w_out_of_range)
            w_cause = CAUSE_RANGE;
    end

    // One aligner serves both directions: request fields while idle, the held op afterwards.
    assign w_idle      = (r_state == S_IDLE);
    assign w_al_funct3 = w_idle ? i_funct3  : r_funct3;
    assign w_al_off    = w_idle ? w_ea[1:0] : r_byte_off;

    lsu_lane_align u_lane_align (
        .i_funct3     (w_al_funct3),
        .i_byte_off   (w_al_off),
        .i_store_data (i_rs2_val),
        .i_mem_rdata  (i_mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_funct3      <= '0;
            r_byte_off    <= '0;
            r_rd          <= '0;
            r_lat_cnt     <= '0;
            r_mem_we      <= 1'b0;
            r_mem_re      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_load_valid  <= 1'b0;
            r_load_rd     <= '0;
            r_load_data   <= '0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= CAUSE_NONE;
        end else begin
            // Every output is a single-cycle pulse unless the next state re-asserts it.
            r_mem_we      <= 1'b0;
            r_mem_re      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_load_valid  <= 1'b0;
            r_load_rd     <= '0;
            r_load_data   <= '0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= CAUSE_NONE;

            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_funct3    <= i_funct3;
                        r_byte_off  <= w_ea[1:0];
                        r_rd        <= i_rd;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_cause != CAUSE_NONE) begin
                            r_state       <= S_FAULT;
                            r_fault       <= 1'b1;
                            r_fault_cause <= w_cause;
                        end else if (i_is_store) begin
                            r_state     <= S_ST_WR;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_ea[ADDR_W+1:2];
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_done      <= 1'b1;
                        end else begin
                            r_state    <= S_LD_REQ;
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= w_ea[ADDR_W+1:2];
                            r_mem_be   <= w_be;
                        end
                    end
                end
                S_LD_REQ: begin
                    r_state   <= S_LD_WAIT;
                    r_lat_cnt <= CNT_W'(RD_LAT - 1);
                end
                S_LD_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_state      <= S_LD_RESP;
                        r_load_valid <= 1'b1;
                        r_load_rd    <= r_rd;
                        r_load_data  <= w_load_data;
                        r_done       <= 1'b1;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_busy        = r_busy;
    assign o_stall_pc    = r_busy | (r_req_ready & i_req_valid);
    assign o_mem_we      = r_mem_we;
    assign o_mem_re      = r_mem_re;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_be      = r_mem_be;
    assign o_load_valid  = r_load_valid;
    assign o_load_rd     = r_load_rd;
    assign o_load_data   = r_load_data;
    assign o_done        = r_done;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_fault_cause;

endmodule
